// File: rtl/snake_pkg.sv
// Shared direction codes, FSM state type and grid helpers for the snake game controller.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int unsigned GRID_W_DEF = 9;
    localparam int unsigned GRID_H_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLACE,
        ST_RUN,
        ST_WAIT,
        ST_OVER
    } state_e;

    function automatic logic [6:0] cell_idx(input logic [3:0] x,
                                            input logic [3:0] y,
                                            input int unsigned grid_w);
        return 7'(y) * 7'(grid_w) + 7'(x);
    endfunction

    // Up/Down differ only in bit 0, as do Left/Right.
    function automatic logic dir_opposite(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_food_placer.sv
// Food placement: free-running LFSR seeds a candidate cell, then a linear scan finds a free one.
module snake_food_placer
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W    = GRID_W_DEF,
    parameter int unsigned GRID_H    = GRID_H_DEF,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [GRID_W*GRID_H-1:0]   body_i,
    input  logic [3:0]                 head_x_i,
    input  logic [3:0]                 head_y_i,
    output logic                       found_o,
    output logic                       full_o,
    output logic [3:0]                 food_x_o,
    output logic [3:0]                 food_y_o
);

    localparam int unsigned CELLS   = GRID_W * GRID_H;
    localparam logic [3:0] W4       = 4'(GRID_W);
    localparam logic [3:0] H4       = 4'(GRID_H);
    localparam logic [3:0] X_LAST   = 4'(GRID_W - 1);
    localparam logic [3:0] Y_LAST   = 4'(GRID_H - 1);
    localparam logic [6:0] SCAN_MAX = 7'(CELLS - 1);

    logic [7:0] lfsr_q, lfsr_d;
    logic       busy_q, busy_d;
    logic [3:0] cand_x_q, cand_x_d;
    logic [3:0] cand_y_q, cand_y_d;
    logic [3:0] food_x_q, food_x_d;
    logic [3:0] food_y_q, food_y_d;
    logic [6:0] scan_q, scan_d;
    logic [3:0] seed_x, seed_y;
    logic       cand_free;

    assign food_x_o = food_x_q;
    assign food_y_o = food_y_q;

    // One conditional subtract suffices: a 4-bit value is below twice either grid dimension.
    assign seed_x = (lfsr_q[3:0] >= W4) ? lfsr_q[3:0] - W4 : lfsr_q[3:0];
    assign seed_y = (lfsr_q[7:4] >= H4) ? lfsr_q[7:4] - H4 : lfsr_q[7:4];

    assign cand_free = !body_i[cell_idx(cand_x_q, cand_y_q, GRID_W)]
                    && !((cand_x_q == head_x_i) && (cand_y_q == head_y_i));

    always_comb begin
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        busy_d   = busy_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        food_x_d = food_x_q;
        food_y_d = food_y_q;
        scan_d   = scan_q;
        found_o  = 1'b0;
        full_o   = 1'b0;

        if (start_i) begin
            busy_d   = 1'b1;
            cand_x_d = seed_x;
            cand_y_d = seed_y;
            scan_d   = '0;
        end else if (busy_q) begin
            if (cand_free) begin
                found_o  = 1'b1;
                busy_d   = 1'b0;
                food_x_d = cand_x_q;
                food_y_d = cand_y_q;
            end else if (scan_q == SCAN_MAX) begin
                full_o = 1'b1;
                busy_d = 1'b0;
            end else begin
                scan_d = scan_q + 7'd1;
                if (cand_x_q == X_LAST) begin
                    cand_x_d = '0;
                    cand_y_d = (cand_y_q == Y_LAST) ? '0 : cand_y_q + 4'd1;
                end else begin
                    cand_x_d = cand_x_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q   <= LFSR_SEED;
            busy_q   <= 1'b0;
            cand_x_q <= '0;
            cand_y_q <= '0;
            food_x_q <= '0;
            food_y_q <= '0;
            scan_q   <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            busy_q   <= busy_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            food_x_q <= food_x_d;
            food_y_q <= food_y_d;
            scan_q   <= scan_d;
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move tick, direction latch, step/collision/eat handling, score and status.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W    = GRID_W_DEF,
    parameter int unsigned GRID_H    = GRID_H_DEF,
    parameter int unsigned TICK_DIV  = 25,
    parameter int unsigned STEP_LAT  = 1,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                       Game_Clk,
    input  logic                       i_Rst_n,
    input  logic                       i_Start,
    input  logic                       i_Btn_Up,
    input  logic                       i_Btn_Down,
    input  logic                       i_Btn_Left,
    input  logic                       i_Btn_Right,
    input  logic [3:0]                 i_Head_X,
    input  logic [3:0]                 i_Head_Y,
    input  logic [GRID_W*GRID_H-1:0]   i_SnakeBody,
    input  logic                       i_Collision,
    output logic                       o_Init,
    output logic                       o_Step,
    output logic [1:0]                 o_Dir,
    output logic [3:0]                 o_Food_X,
    output logic [3:0]                 o_Food_Y,
    output logic                       o_Food_Valid,
    output logic [7:0]                 o_Score,
    output logic                       o_Game_Over,
    output logic                       o_Win
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned LW = $clog2(STEP_LAT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(STEP_LAT - 1);

    state_e         state_q, state_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [LW-1:0]  lat_q, lat_d;
    logic [1:0]     dir_q, dir_d;
    logic [1:0]     pend_q, pend_d;
    logic [7:0]     score_q, score_d;
    logic           food_valid_q, food_valid_d;
    logic           over_q, over_d;
    logic           win_q, win_d;

    logic           place_start;
    logic           food_found;
    logic           board_full;
    logic           start_ok;
    logic           btn_any;
    logic [1:0]     btn_dir;
    logic           head_on_food;

    snake_food_placer #(
        .GRID_W    (GRID_W),
        .GRID_H    (GRID_H),
        .LFSR_SEED (LFSR_SEED)
    ) u_placer (
        .clk_i    (Game_Clk),
        .rst_ni   (i_Rst_n),
        .start_i  (place_start),
        .body_i   (i_SnakeBody),
        .head_x_i (i_Head_X),
        .head_y_i (i_Head_Y),
        .found_o  (food_found),
        .full_o   (board_full),
        .food_x_o (o_Food_X),
        .food_y_o (o_Food_Y)
    );

    assign o_Dir        = dir_q;
    assign o_Score      = score_q;
    assign o_Food_Valid = food_valid_q;
    assign o_Game_Over  = over_q;
    assign o_Win        = win_q;

    assign start_ok     = i_Start && ((state_q == ST_IDLE) || (state_q == ST_OVER));
    assign btn_any      = i_Btn_Up || i_Btn_Down || i_Btn_Left || i_Btn_Right;
    assign head_on_food = food_valid_q && (i_Head_X == o_Food_X) && (i_Head_Y == o_Food_Y);

    always_comb begin
        btn_dir = DIR_RIGHT;
        if (i_Btn_Up) begin
            btn_dir = DIR_UP;
        end else if (i_Btn_Down) begin
            btn_dir = DIR_DOWN;
        end else if (i_Btn_Left) begin
            btn_dir = DIR_LEFT;
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        lat_d        = lat_q;
        dir_d        = dir_q;
        pend_d       = pend_q;
        score_d      = score_q;
        food_valid_d = food_valid_q;
        over_d       = over_q;
        win_d        = win_q;
        o_Init       = 1'b0;
        o_Step       = 1'b0;
        place_start  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (i_Start) begin
                    o_Init       = 1'b1;
                    place_start  = 1'b1;
                    score_d      = '0;
                    dir_d        = DIR_RIGHT;
                    tick_d       = '0;
                    food_valid_d = 1'b0;
                    over_d       = 1'b0;
                    win_d        = 1'b0;
                    state_d      = ST_PLACE;
                end
            end
            ST_PLACE: begin
                if (food_found) begin
                    food_valid_d = 1'b1;
                    tick_d       = '0;
                    state_d      = ST_RUN;
                end else if (board_full) begin
                    over_d  = 1'b1;
                    win_d   = 1'b1;
                    state_d = ST_OVER;
                end
            end
            ST_RUN: begin
                if (tick_q == TICK_LAST) begin
                    o_Step  = 1'b1;
                    dir_d   = pend_q;
                    tick_d  = '0;
                    lat_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    if (i_Collision) begin
                        over_d  = 1'b1;
                        state_d = ST_OVER;
                    end else if (head_on_food) begin
                        score_d      = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        food_valid_d = 1'b0;
                        place_start  = 1'b1;
                        state_d      = ST_PLACE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Reversal is judged against the direction committed after this edge, so a press in the
        // step cycle cannot queue a reversal of the direction just taken.
        if (start_ok) begin
            pend_d = DIR_RIGHT;
        end else if (btn_any && !dir_opposite(btn_dir, dir_d)) begin
            pend_d = btn_dir;
        end
    end

    always_ff @(posedge Game_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            lat_q        <= '0;
            dir_q        <= DIR_RIGHT;
            pend_q       <= DIR_RIGHT;
            score_q      <= '0;
            food_valid_q <= 1'b0;
            over_q       <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            lat_q        <= lat_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            score_q      <= score_d;
            food_valid_q <= food_valid_d;
            over_q       <= over_d;
            win_q        <= win_d;
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: direction table, hand-written corner sequences, random rounds.
module tb_snake_game_ctrl;

    localparam int GW = 9;
    localparam int GH = 10;
    localparam int D_UP = 0, D_DOWN = 1, D_LEFT = 2, D_RIGHT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        bu, bd, bl, br;
    logic [3:0]  hx, hy;
    logic [89:0] body;
    logic        coll;
    logic        o_Init, o_Step, o_Food_Valid, o_Game_Over, o_Win;
    logic [1:0]  o_Dir;
    logic [3:0]  o_Food_X, o_Food_Y;
    logic [7:0]  o_Score;

    int checks = 0;
    int errors = 0;
    int m_dir, m_pend, m_score;

    typedef struct {
        logic [3:0] m1;
        logic [3:0] m2;
        int         exp_dir;
    } dir_vec_t;

    dir_vec_t vecs[11];

    always #5 clk = ~clk;

    snake_game_ctrl #(
        .GRID_W    (9),
        .GRID_H    (10),
        .TICK_DIV  (4),
        .STEP_LAT  (1),
        .LFSR_SEED (8'hA5)
    ) dut (
        .Game_Clk     (clk),
        .i_Rst_n      (rst_n),
        .i_Start      (start),
        .i_Btn_Up     (bu),
        .i_Btn_Down   (bd),
        .i_Btn_Left   (bl),
        .i_Btn_Right  (br),
        .i_Head_X     (hx),
        .i_Head_Y     (hy),
        .i_SnakeBody  (body),
        .i_Collision  (coll),
        .o_Init       (o_Init),
        .o_Step       (o_Step),
        .o_Dir        (o_Dir),
        .o_Food_X     (o_Food_X),
        .o_Food_Y     (o_Food_Y),
        .o_Food_Valid (o_Food_Valid),
        .o_Score      (o_Score),
        .o_Game_Over  (o_Game_Over),
        .o_Win        (o_Win)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int opposite(input int d);
        case (d)
            D_UP:    return D_DOWN;
            D_DOWN:  return D_UP;
            D_LEFT:  return D_RIGHT;
            default: return D_LEFT;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // mask bits {Up, Down, Left, Right}; held for one rising edge
    task automatic press(input logic [3:0] mask);
        int d;
        {bu, bd, bl, br} = mask;
        d = mask[3] ? D_UP : mask[2] ? D_DOWN : mask[1] ? D_LEFT : D_RIGHT;
        if (mask != 4'h0 && d != opposite(m_dir)) m_pend = d;
        cyc();
        {bu, bd, bl, br} = 4'h0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_init"}, o_Init, 0);
        chk({tag, "_step"}, o_Step, 0);
        chk({tag, "_dir"}, o_Dir, D_RIGHT);
        chk({tag, "_food_xy"}, {o_Food_Y, o_Food_X}, 0);
        chk({tag, "_food_valid"}, o_Food_Valid, 0);
        chk({tag, "_score"}, o_Score, 0);
        chk({tag, "_over"}, o_Game_Over, 0);
        chk({tag, "_win"}, o_Win, 0);
    endtask

    task automatic wait_step(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (o_Step) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("step_timeout", 0, 1);
    endtask

    task automatic wait_food(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 92; i++) begin
            if (o_Food_Valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("food_within_91", ok, 1);
    endtask

    task automatic check_food();
        int fx, fy;
        fx = o_Food_X;
        fy = o_Food_Y;
        chk("food_x_range", fx < GW, 1);
        chk("food_y_range", fy < GH, 1);
        if (fx < GW && fy < GH) chk("food_cell_free", body[fy * GW + fx], 0);
        chk("food_not_head", (fx == hx) && (fy == hy), 0);
    endtask

    // Called at the negedge of a step cycle. outcome: 0 plain move, 1 eat, 2 collide onto food.
    task automatic after_step(input int outcome, input int exp_dir);
        cyc();
        chk("dir_after_step", o_Dir, exp_dir);
        chk("step_one_cycle", o_Step, 0);
        m_dir  = exp_dir;
        m_pend = exp_dir;
        if (outcome != 0) begin
            hx = o_Food_X;
            hy = o_Food_Y;
        end else begin
            hx = (o_Food_X == 4'd0) ? 4'd1 : 4'd0;
            hy = o_Food_Y;
        end
        coll = (outcome == 2);
        cyc();
        coll = 1'b0;
        @(negedge clk);
        if (outcome == 1 && m_score < 255) m_score++;
        chk("score", o_Score, m_score);
        chk("game_over", o_Game_Over, outcome == 2);
        chk("food_valid_after", o_Food_Valid, outcome != 1);
    endtask

    task automatic do_start();
        cyc();
        start = 1'b1;
        @(negedge clk);
        chk("init_pulse", o_Init, 1);
        cyc();
        start   = 1'b0;
        m_score = 0;
        m_dir   = D_RIGHT;
        m_pend  = D_RIGHT;
        @(negedge clk);
        chk("init_one_cycle", o_Init, 0);
        chk("start_score", o_Score, 0);
        chk("start_over", o_Game_Over, 0);
        chk("start_win", o_Win, 0);
        chk("start_dir", o_Dir, D_RIGHT);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        logic [95:0] r;

        vecs[0]  = '{4'h2, 4'h0, D_RIGHT};
        vecs[1]  = '{4'h8, 4'h4, D_DOWN};
        vecs[2]  = '{4'h8, 4'h0, D_DOWN};
        vecs[3]  = '{4'h2, 4'h0, D_LEFT};
        vecs[4]  = '{4'h1, 4'h0, D_LEFT};
        vecs[5]  = '{4'hC, 4'h0, D_UP};
        vecs[6]  = '{4'h3, 4'h0, D_LEFT};
        vecs[7]  = '{4'h4, 4'h1, D_DOWN};
        vecs[8]  = '{4'h0, 4'h0, D_DOWN};
        vecs[9]  = '{4'h9, 4'h0, D_DOWN};
        vecs[10] = '{4'h1, 4'h8, D_RIGHT};

        rst_n = 1'b0;
        start = 1'b0;
        {bu, bd, bl, br} = 4'h0;
        hx = 4'd2;
        hy = 4'd5;
        body = '0;
        coll = 1'b0;
        m_dir = D_RIGHT;
        m_pend = D_RIGHT;
        m_score = 0;

        // Reset, start, first food and first step timing
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        do_start();
        wait_food(ok);
        check_food();
        n = 1;
        while (!o_Step && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_step_cycle_in_run", n, 4);
        after_step(0, D_RIGHT);

        // Direction latch table
        foreach (vecs[i]) begin
            if (vecs[i].m1 != 4'h0) press(vecs[i].m1); else cyc();
            if (vecs[i].m2 != 4'h0) press(vecs[i].m2); else cyc();
            wait_step(ok);
            after_step(0, vecs[i].exp_dir);
        end

        // Eat: score increments, food replaced on a free cell
        body = 90'h0F0_0000_FFFF_0000_00FF;
        wait_step(ok);
        after_step(1, m_pend);
        wait_food(ok);
        check_food();

        // Nearly full board, then full board
        body = '0;
        for (int k = 0; k < 4 && o_Food_X == 4'd8 && o_Food_Y == 4'd9; k++) begin
            wait_step(ok);
            after_step(1, m_pend);
            wait_food(ok);
        end
        wait_step(ok);
        body = '1;
        body[89] = 1'b0;
        after_step(1, m_pend);
        wait_food(ok);
        chk("last_cell_x", o_Food_X, 8);
        chk("last_cell_y", o_Food_Y, 9);
        wait_step(ok);
        body = '1;
        after_step(1, m_pend);
        ok = 1'b0;
        for (int i = 0; i < 95; i++) begin
            if (o_Game_Over) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("full_board_over", o_Game_Over, 1);
        chk("full_board_win", o_Win, 1);
        chk("full_board_score", o_Score, m_score);

        // Restart, eat once, then collision on the food cell
        body = '0;
        do_start();
        wait_food(ok);
        check_food();
        press(4'h8);
        wait_step(ok);
        after_step(1, D_UP);
        wait_food(ok);
        wait_step(ok);
        after_step(2, m_pend);
        chk("collide_no_win", o_Win, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_Step) n++;
        end
        chk("no_step_when_over", n, 0);
        chk("over_held", o_Game_Over, 1);
        do_start();

        // Asynchronous reset during WAIT and during PLACE
        wait_food(ok);
        wait_step(ok);
        after_step(1, m_pend);
        wait_food(ok);
        wait_step(ok);
        cyc();
        rst_n = 1'b0;
        #1;
        chk_reset("rst_wait");
        @(negedge clk);
        chk("rst_wait_held_step", o_Step, 0);
        rst_n = 1'b1;
        m_score = 0;
        m_dir = D_RIGHT;
        m_pend = D_RIGHT;
        hx = 4'd2;
        hy = 4'd5;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_place");
        @(negedge clk);
        rst_n = 1'b1;

        // Random rounds against the sequence-level model, driving the score into saturation
        do_start();
        wait_food(ok);
        for (int rnd = 0; rnd < 300 || (m_score < 256 && rnd < 600 && o_Score != 8'hFF); rnd++) begin
            int outcome;
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(1, 0) == 1) press(4'($urandom_range(15, 1)));
                else cyc();
            end
            wait_step(ok);
            outcome = ($urandom_range(9, 0) != 0) ? 1 : 0;
            if (outcome == 1) begin
                r = {$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom};
                body = r[89:0];
                body[$urandom_range(89, 0)] = 1'b0;
            end
            after_step(outcome, m_pend);
            if (outcome == 1) begin
                wait_food(ok);
                check_food();
            end
        end
        wait_step(ok);
        after_step(1, m_pend);
        chk("score_saturated", o_Score, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
